// File: rtl/reservation_station_if.sv
// Reservation station bundle: issue-stage allocation, CDB broadcast and FU issue handshake.
// Shared type macros are guarded so every file of the bundle can define them identically.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef FU_W
`define FU_W 3
`endif
`ifndef FU_ALU
`define FU_ALU 3'b001
`endif
`ifndef ID_EX_PACKET
`define ID_EX_PACKET struct packed { \
    logic [6:0]       opcode;    \
    logic [4:0]       dest_reg;  \
    logic [3:0]       alu_func;  \
    logic [`XLEN-1:0] rs1_value; \
    logic [`XLEN-1:0] rs2_value; \
}
`endif

interface reservation_station_if;
    typedef `ID_EX_PACKET id_ex_packet_t;

    logic [`FU_W-1:0]        rs_enable;
    logic                    alloc_valid;
    id_ex_packet_t           id_packet_in;
    logic [`ROB_TAG_LEN-1:0] rs1_tag;
    logic [`ROB_TAG_LEN-1:0] rs2_tag;
    logic [`ROB_TAG_LEN-1:0] dest_tag;
    logic                    cdb_valid;
    logic [`ROB_TAG_LEN-1:0] cdb_tag;
    logic [`XLEN-1:0]        cdb_value;
    logic                    squash;
    logic                    fu_ready;
    logic                    full;
    logic                    issue_valid;
    id_ex_packet_t           issue_packet;
    logic [`ROB_TAG_LEN-1:0] issue_dest_tag;

    modport master (
        output rs_enable, alloc_valid, id_packet_in, rs1_tag, rs2_tag, dest_tag,
        output cdb_valid, cdb_tag, cdb_value, squash, fu_ready,
        input  full, issue_valid, issue_packet, issue_dest_tag
    );

    modport slave (
        input  rs_enable, alloc_valid, id_packet_in, rs1_tag, rs2_tag, dest_tag,
        input  cdb_valid, cdb_tag, cdb_value, squash, fu_ready,
        output full, issue_valid, issue_packet, issue_dest_tag
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds instructions until both operands arrive from the CDB, then issues.
// Define RS_OLDEST_FIRST_EN for oldest-ready selection; default picks the lowest-index ready entry.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef FU_W
`define FU_W 3
`endif
`ifndef FU_ALU
`define FU_ALU 3'b001
`endif
`ifndef ID_EX_PACKET
`define ID_EX_PACKET struct packed { \
    logic [6:0]       opcode;    \
    logic [4:0]       dest_reg;  \
    logic [3:0]       alu_func;  \
    logic [`XLEN-1:0] rs1_value; \
    logic [`XLEN-1:0] rs2_value; \
}
`endif

module reservation_station #(
    parameter int unsigned      RS_SIZE = 4,
    parameter logic [`FU_W-1:0] FU_ID   = `FU_ALU
) (
    input logic                  clock,
    input logic                  reset,
    reservation_station_if.slave bus
);
    localparam int unsigned IdxW = $clog2(RS_SIZE);
    localparam int unsigned TagW = `ROB_TAG_LEN;

    typedef `ID_EX_PACKET pkt_t;

    // Operand values live in the stored packet's rs1_value/rs2_value fields.
    logic [RS_SIZE-1:0] valid_q, valid_d;
    pkt_t               pkt_q  [RS_SIZE];
    pkt_t               pkt_d  [RS_SIZE];
    logic [TagW-1:0]    dest_q [RS_SIZE];
    logic [TagW-1:0]    dest_d [RS_SIZE];
    logic [TagW-1:0]    t1_q   [RS_SIZE];
    logic [TagW-1:0]    t1_d   [RS_SIZE];
    logic [TagW-1:0]    t2_q   [RS_SIZE];
    logic [TagW-1:0]    t2_d   [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
    logic [2:0]         age_q  [RS_SIZE];
    logic [2:0]         age_d  [RS_SIZE];
    logic [2:0]         best_age;
`endif

    logic [RS_SIZE-1:0] ready;
    logic               sel_found;
    logic [IdxW-1:0]    sel_idx;
    logic [IdxW-1:0]    free_idx;
    logic               full;
    logic               cdb_live;
    logic               alloc_en;
    logic               issue_fire;

    assign full       = &valid_q;
    assign cdb_live   = bus.cdb_valid && (bus.cdb_tag != '0);
    assign alloc_en   = bus.alloc_valid && (bus.rs_enable == FU_ID) && !full && !bus.squash;
    assign sel_found  = |ready;
    assign issue_fire = sel_found && bus.fu_ready;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid_q[i] && (t1_q[i] == '0) && (t2_q[i] == '0);
        end
    end

    // Scanning downward lets the last hit win, giving lowest-index priority.
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IdxW'(i);
        end
    end

    always_comb begin
        sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i] && (age_q[i] >= best_age)) begin
                sel_idx  = IdxW'(i);
                best_age = age_q[i];
            end
        end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = IdxW'(i);
        end
`endif
    end

    always_comb begin
        bus.issue_packet   = '0;
        bus.issue_dest_tag = '0;
        if (sel_found) begin
            bus.issue_packet   = pkt_q[sel_idx];
            bus.issue_dest_tag = dest_q[sel_idx];
        end
    end

    assign bus.issue_valid = sel_found;
    assign bus.full        = full;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        dest_d  = dest_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
`ifdef RS_OLDEST_FIRST_EN
        age_d   = age_q;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && cdb_live) begin
                if (t1_q[i] == bus.cdb_tag) begin
                    t1_d[i]           = '0;
                    pkt_d[i].rs1_value = bus.cdb_value;
                end
                if (t2_q[i] == bus.cdb_tag) begin
                    t2_d[i]           = '0;
                    pkt_d[i].rs2_value = bus.cdb_value;
                end
            end
`ifdef RS_OLDEST_FIRST_EN
            if (valid_q[i] && (age_q[i] != 3'd7)) age_d[i] = age_q[i] + 3'd1;
`endif
        end

        if (issue_fire) valid_d[sel_idx] = 1'b0;

        // A free slot is never the selected one, so allocation cannot collide with issue.
        if (alloc_en) begin
            valid_d[free_idx] = 1'b1;
            pkt_d[free_idx]   = bus.id_packet_in;
            dest_d[free_idx]  = bus.dest_tag;
            t1_d[free_idx]    = bus.rs1_tag;
            t2_d[free_idx]    = bus.rs2_tag;
`ifdef RS_OLDEST_FIRST_EN
            age_d[free_idx]   = '0;
`endif
            if (cdb_live && (bus.rs1_tag == bus.cdb_tag)) begin
                t1_d[free_idx]           = '0;
                pkt_d[free_idx].rs1_value = bus.cdb_value;
            end
            if (cdb_live && (bus.rs2_tag == bus.cdb_tag)) begin
                t2_d[free_idx]           = '0;
                pkt_d[free_idx].rs2_value = bus.cdb_value;
            end
        end

        if (bus.squash) valid_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                pkt_q[i]  <= '0;
                dest_q[i] <= '0;
                t1_q[i]   <= '0;
                t2_q[i]   <= '0;
`ifdef RS_OLDEST_FIRST_EN
                age_q[i]  <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            dest_q  <= dest_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
`ifdef RS_OLDEST_FIRST_EN
            age_q   <= age_d;
`endif
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios then random traffic against a slot-level model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef FU_W
`define FU_W 3
`endif
`ifndef FU_ALU
`define FU_ALU 3'b001
`endif
`ifndef ID_EX_PACKET
`define ID_EX_PACKET struct packed { \
    logic [6:0]       opcode;    \
    logic [4:0]       dest_reg;  \
    logic [3:0]       alu_func;  \
    logic [`XLEN-1:0] rs1_value; \
    logic [`XLEN-1:0] rs2_value; \
}
`endif

module tb_reservation_station;
    localparam int RS = 4;
    localparam int TW = `ROB_TAG_LEN;
    localparam logic [`FU_W-1:0] FuMul = 3'b010;

    typedef `ID_EX_PACKET pkt_t;
    typedef struct {
        bit            v;
        pkt_t          pkt;
        logic [TW-1:0] dest;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        int            born;
    } ment_t;

    logic clock;
    logic reset;
    reservation_station_if bus ();

    reservation_station #(.RS_SIZE(RS), .FU_ID(`FU_ALU)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ment_t m [RS];
    int    edge_cnt;
    int    tests_run;
    int    fails;
    int    exp_first;
    int    exp_second;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", nm, obs, exp);
        end
    endtask

    function automatic bit mfull();
        for (int i = 0; i < RS; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // Ready slot chosen by the selection rule; -1 when none is ready.
    function automatic int msel();
        int best;
        int bage;
        int a;
        best = -1;
        bage = -1;
        for (int i = 0; i < RS; i++) begin
            if (m[i].v && m[i].t1 == '0 && m[i].t2 == '0) begin
`ifdef RS_OLDEST_FIRST_EN
                a = edge_cnt - m[i].born;
                if (a > 7) a = 7;
                if (a > bage) begin
                    best = i;
                    bage = a;
                end
`else
                a = i;
                if (best < 0) best = a;
`endif
            end
        end
        return best;
    endfunction

    function automatic void mclear();
        for (int i = 0; i < RS; i++) m[i].v = 1'b0;
    endfunction

    function automatic void mupdate(input int s);
        int fi;
        bit wasfull;
        wasfull = mfull();
        fi = -1;
        for (int i = 0; i < RS; i++) if (!m[i].v && fi < 0) fi = i;
        if (bus.squash) begin
            mclear();
        end else begin
            for (int i = 0; i < RS; i++) begin
                if (m[i].v && bus.cdb_valid && bus.cdb_tag != '0) begin
                    if (m[i].t1 == bus.cdb_tag) begin
                        m[i].t1 = '0;
                        m[i].pkt.rs1_value = bus.cdb_value;
                    end
                    if (m[i].t2 == bus.cdb_tag) begin
                        m[i].t2 = '0;
                        m[i].pkt.rs2_value = bus.cdb_value;
                    end
                end
            end
            if (s >= 0 && bus.fu_ready) m[s].v = 1'b0;
            if (bus.alloc_valid && bus.rs_enable == `FU_ALU && !wasfull) begin
                m[fi].v    = 1'b1;
                m[fi].pkt  = bus.id_packet_in;
                m[fi].dest = bus.dest_tag;
                m[fi].t1   = bus.rs1_tag;
                m[fi].t2   = bus.rs2_tag;
                m[fi].born = edge_cnt + 1;
                if (bus.cdb_valid && bus.cdb_tag != '0 && bus.rs1_tag == bus.cdb_tag) begin
                    m[fi].t1 = '0;
                    m[fi].pkt.rs1_value = bus.cdb_value;
                end
                if (bus.cdb_valid && bus.cdb_tag != '0 && bus.rs2_tag == bus.cdb_tag) begin
                    m[fi].t2 = '0;
                    m[fi].pkt.rs2_value = bus.cdb_value;
                end
            end
        end
        edge_cnt++;
    endfunction

    // Compare outputs with the model, advance the model, then cross one clock edge.
    task automatic tick();
        int            s;
        pkt_t          ep;
        logic [TW-1:0] ed;
        s  = msel();
        ep = '0;
        ed = '0;
        if (s >= 0) begin
            ep = m[s].pkt;
            ed = m[s].dest;
        end
        check("model_full", 128'(bus.full), 128'(mfull()));
        check("model_issue_valid", 128'(bus.issue_valid), 128'(s >= 0));
        check("model_issue_packet", 128'(bus.issue_packet), 128'(ep));
        check("model_issue_dest", 128'(bus.issue_dest_tag), 128'(ed));
        mupdate(s);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.rs_enable    = `FU_ALU;
        bus.alloc_valid  = 1'b0;
        bus.id_packet_in = '0;
        bus.rs1_tag      = '0;
        bus.rs2_tag      = '0;
        bus.dest_tag     = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.squash       = 1'b0;
        bus.fu_ready     = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] v1, input logic [31:0] v2,
                         input logic [TW-1:0] tg1, input logic [TW-1:0] tg2,
                         input logic [TW-1:0] dst);
        bus.alloc_valid            = 1'b1;
        bus.rs_enable              = `FU_ALU;
        bus.id_packet_in.opcode    = 7'h33;
        bus.id_packet_in.dest_reg  = 5'd3;
        bus.id_packet_in.alu_func  = 4'd0;
        bus.id_packet_in.rs1_value = v1;
        bus.id_packet_in.rs2_value = v2;
        bus.rs1_tag                = tg1;
        bus.rs2_tag                = tg2;
        bus.dest_tag               = dst;
    endtask

    task automatic cdb(input logic [TW-1:0] tg, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tg;
        bus.cdb_value = val;
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        edge_cnt  = 0;
        mclear();
        idle();
        reset = 1'b1;
        #1;
        check("reset_full", 128'(bus.full), 128'(1'b0));
        check("reset_issue_valid", 128'(bus.issue_valid), 128'(1'b0));
        check("reset_issue_packet", 128'(bus.issue_packet), 128'(0));
        check("reset_issue_dest", 128'(bus.issue_dest_tag), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Ready-on-alloc ADD issues the next cycle and frees.
        alloc(32'd5, 32'd7, '0, '0, 5'd1);
        bus.fu_ready = 1'b1;
        tick();
        idle();
        bus.fu_ready = 1'b1;
        check("add_valid", 128'(bus.issue_valid), 128'(1'b1));
        check("add_rs1", 128'(bus.issue_packet.rs1_value), 128'(32'd5));
        check("add_rs2", 128'(bus.issue_packet.rs2_value), 128'(32'd7));
        check("add_dest", 128'(bus.issue_dest_tag), 128'(5'd1));
        tick();
        idle();
        check("add_freed", 128'(bus.issue_valid), 128'(1'b0));

        // CDB wakeup of a waiting rs2.
        alloc(32'd0, 32'd0, '0, 5'd3, 5'd2);
        tick();
        idle();
        check("wake_wait", 128'(bus.issue_valid), 128'(1'b0));
        cdb(5'd3, 32'h2A);
        tick();
        idle();
        check("wake_valid", 128'(bus.issue_valid), 128'(1'b1));
        check("wake_rs2", 128'(bus.issue_packet.rs2_value), 128'(32'h2A));
        bus.fu_ready = 1'b1;
        tick();

        // Same-cycle capture on allocation.
        idle();
        alloc(32'd0, 32'd0, 5'd4, '0, 5'd3);
        cdb(5'd4, 32'd9);
        tick();
        idle();
        check("cap_valid", 128'(bus.issue_valid), 128'(1'b1));
        check("cap_rs1", 128'(bus.issue_packet.rs1_value), 128'(32'd9));
        bus.fu_ready = 1'b1;
        tick();

        // Tag 0 on the CDB must not disturb a ready operand.
        idle();
        alloc(32'h11, 32'h22, '0, '0, 5'd12);
        tick();
        idle();
        cdb('0, 32'hFF);
        tick();
        idle();
        check("tag0_rs1", 128'(bus.issue_packet.rs1_value), 128'(32'h11));
        check("tag0_rs2", 128'(bus.issue_packet.rs2_value), 128'(32'h22));
        bus.fu_ready = 1'b1;
        tick();

        // Fill, ignore alloc while full, free one.
        for (int k = 0; k < 4; k++) begin
            idle();
            alloc(32'd0, 32'd0, TW'(k < 2 ? k + 1 : k + 3), '0, TW'(k + 4));
            tick();
        end
        idle();
        check("fill_full", 128'(bus.full), 128'(1'b1));
        alloc(32'd1, 32'd1, '0, '0, 5'd20);
        tick();
        idle();
        check("full_ignore_full", 128'(bus.full), 128'(1'b1));
        check("full_ignore_valid", 128'(bus.issue_valid), 128'(1'b0));
        cdb(5'd2, 32'h77);
        bus.fu_ready = 1'b1;
        tick();
        idle();
        bus.fu_ready = 1'b1;
        check("free_valid", 128'(bus.issue_valid), 128'(1'b1));
        check("free_dest", 128'(bus.issue_dest_tag), 128'(5'd5));
        check("free_still_full", 128'(bus.full), 128'(1'b1));
        tick();
        idle();
        check("free_full_clear", 128'(bus.full), 128'(1'b0));

        // Squash overrides a simultaneous allocation.
        alloc(32'd0, 32'd0, 5'd3, 5'd3, 5'd21);
        tick();
        idle();
        check("sq_full_before", 128'(bus.full), 128'(1'b1));
        alloc(32'd1, 32'd2, '0, '0, 5'd22);
        bus.squash = 1'b1;
        tick();
        idle();
        check("sq_full", 128'(bus.full), 128'(1'b0));
        check("sq_valid", 128'(bus.issue_valid), 128'(1'b0));
        tick();
        check("sq_no_alloc", 128'(bus.issue_valid), 128'(1'b0));

        // Older entry 2 versus newer entry 0, both ready together.
        idle(); alloc(32'd0, 32'd0, 5'd1, '0, 5'd8);  tick();
        idle(); alloc(32'd0, 32'd0, 5'd2, '0, 5'd9);  tick();
        idle(); alloc(32'd0, 32'd0, 5'd3, '0, 5'd10); tick();
        idle(); cdb(5'd1, 32'hA1); tick();
        idle(); bus.fu_ready = 1'b1; tick();
        idle(); alloc(32'd0, 32'd0, 5'd4, '0, 5'd11); tick();
        idle(); cdb(5'd3, 32'hA3); tick();
        idle(); cdb(5'd4, 32'hA4); tick();
        idle();
`ifdef RS_OLDEST_FIRST_EN
        exp_first  = 10;
        exp_second = 11;
`else
        exp_first  = 11;
        exp_second = 10;
`endif
        check("age_first", 128'(bus.issue_dest_tag), 128'(exp_first));
        bus.fu_ready = 1'b1;
        tick();
        idle();
        check("age_second", 128'(bus.issue_dest_tag), 128'(exp_second));
        bus.squash = 1'b1;
        tick();

        // Random traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                idle();
                #2;
                reset = 1'b1;
                #1;
                mclear();
                check("midreset_full", 128'(bus.full), 128'(1'b0));
                check("midreset_valid", 128'(bus.issue_valid), 128'(1'b0));
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
            idle();
            if ($urandom_range(0, 9) < 6) begin
                bus.alloc_valid            = 1'b1;
                bus.rs_enable              = ($urandom_range(0, 7) == 0) ? FuMul : `FU_ALU;
                bus.id_packet_in.opcode    = 7'($urandom);
                bus.id_packet_in.dest_reg  = 5'($urandom);
                bus.id_packet_in.alu_func  = 4'($urandom);
                bus.id_packet_in.rs1_value = $urandom;
                bus.id_packet_in.rs2_value = $urandom;
                bus.rs1_tag  = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 7));
                bus.rs2_tag  = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 7));
                bus.dest_tag = TW'($urandom_range(1, 31));
            end
            bus.cdb_valid = 1'($urandom_range(0, 1));
            bus.cdb_tag   = TW'($urandom_range(0, 7));
            bus.cdb_value = $urandom;
            bus.squash    = ($urandom_range(0, 39) == 0);
            bus.fu_ready  = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 4, number of entries (power of two, 2..16).
REQ-002 SHALL have parameter FU_ID, default `FU_ALU, FU class this instance serves; compared against rs_enable.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rs_enable  input  width of `FU_ALU  FU class selected by the issue stage.
REQ-006 alloc_valid  input  1  issue stage presents a new instruction this cycle.
REQ-007 id_packet_in  input  ID_EX_PACKET  decoded instruction with rs1_value and rs2_value.
REQ-008 rs1_tag, rs2_tag  input  `ROB_TAG_LEN each  producer ROB tag; 0 = operand value already valid.
REQ-009 dest_tag  input  `ROB_TAG_LEN  ROB tag allocated to the new instruction.
REQ-010 cdb_valid  input  1; cdb_tag  input  `ROB_TAG_LEN; cdb_value  input  `XLEN  common data bus broadcast.
REQ-011 squash  input  1  pipeline flush.
REQ-012 fu_ready  input  1  downstream FU accepts an instruction this cycle.
REQ-013 full  output  1  no free entry.
REQ-014 issue_valid  output  1  issue_packet holds a ready instruction.
REQ-015 issue_packet  output  ID_EX_PACKET  selected instruction with both operand values resolved.
REQ-016 issue_dest_tag  output  `ROB_TAG_LEN  ROB tag of the issued instruction.

Function
REQ-017 Allocation SHALL occur at a clock edge iff alloc_valid & (rs_enable == FU_ID) & ~full & ~squash, into the lowest-index free entry.
REQ-018 An entry SHALL store the packet, dest_tag, and per operand a value plus a waiting tag (0 = ready).
REQ-019 On allocation, an operand whose tag equals cdb_tag while cdb_valid is high SHALL capture cdb_value and be stored ready.
REQ-020 Each cycle with cdb_valid, every valid entry's nonzero operand tag equal to cdb_tag SHALL load cdb_value and clear the tag to 0.
REQ-021 An entry SHALL be ready when valid and both tags are 0; issue selection is combinational over registered state.
REQ-022 issue_valid SHALL be high iff at least one entry is ready; issue_packet/issue_dest_tag SHALL come from the selected entry, else be all zero.
REQ-023 The selected entry SHALL be freed at the edge where issue_valid & fu_ready; otherwise it is held with outputs stable.
REQ-024 Minimum latency SHALL be one cycle: an instruction allocated ready at edge N can issue in cycle N+1; CDB wakeup at edge N permits issue in cycle N+1.
REQ-025 full SHALL equal all entries valid from registered state; an entry freed in the same cycle does not clear full until the next edge.
REQ-026 Alloc with full high SHALL be ignored without state change; the issue stage stalls on full.
REQ-027 squash SHALL invalidate all entries at the next edge, override allocation and issue-free, and yield full=0 and issue_valid=0 the cycle after.
REQ-028 Tag 0 on the CDB SHALL never wake an operand.

Reset
REQ-029 reset SHALL immediately clear all valid bits, tags, values and age state; full=0, issue_valid=0, issue_packet=0, issue_dest_tag=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; no issue occurs in the cycle reset deasserts.

Configuration
REQ-031 With macro RS_OLDEST_FIRST_EN defined, each entry SHALL hold a 3-bit age, 0 at allocation, incremented saturating at 7 on every edge while valid; selection SHALL pick the ready entry with the highest age, ties to the lowest index.
REQ-032 Without RS_OLDEST_FIRST_EN, no age state SHALL exist and selection SHALL pick the lowest-index ready entry.

Verification
REQ-033 Allocate ADD, rs1_tag=0, rs2_tag=0, values 5/7, fu_ready=1 -> next cycle issue_valid=1, rs1_value=5, rs2_value=7, entry freed.
REQ-034 Allocate with rs2_tag=3, then cdb_valid=1, cdb_tag=3, cdb_value=0x2A -> issue next cycle with rs2_value=0x2A.
REQ-035 Allocate with rs1_tag=4 in the same cycle as CDB tag 4, value 9 -> stored ready, issues next cycle with rs1_value=9.
REQ-036 Fill 4 entries with unresolved tags -> full=1; fifth alloc ignored; one wakeup plus fu_ready=1 -> full=0 the cycle after the free edge.
REQ-037 4 entries valid, assert squash with alloc_valid=1 -> next cycle full=0, issue_valid=0, no entry allocated.
REQ-038 With RS_OLDEST_FIRST_EN, entries 0 (newer) and 2 (older) both ready -> entry 2 issues first; without macro, entry 0 issues first.
